// File: rtl/alu_iter_exec_if.sv
// alu_iter_exec_if: operation request / result bundle for alu_iter_exec.
//   master : upstream control side (drives operation and out_ready)
//   slave  : the execute unit (drives in_ready, out_valid, result, zero, illegal)
// Signals:
//   in_valid/in_ready   - operation handshake (alu_op, op_a, op_b)
//   out_valid/out_ready - result handshake (result, zero, illegal)
interface alu_iter_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: iterative execute-stage ALU.
// Logic ops, ADD/SUB/SLT finish in one cycle; shifts move one bit per cycle;
// MUL is a 32-step unsigned shift-add producing the low 32 bits.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_iter_exec_if slave: in_valid/in_ready, alu_op, op_a, op_b,
//           out_valid/out_ready, result, zero, illegal
module alu_iter_exec #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input logic               clk,
    input logic               rst_n,
    alu_iter_exec_if.slave    bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      op_q;
    logic [XLEN-1:0] acc, mcand, mplier;
    logic [5:0]      count;
    logic [XLEN-1:0] result_q;
    logic            zero_q, illegal_q;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT,
            OP_SLL, OP_SRL, OP_SRA: return 1'b1;
            OP_MUL:                 return (MUL_EN != 0);
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] simple_op(input logic [3:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            OP_SUB:  return a - b;
            OP_SLT:  return XLEN'(sa < sb);
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                  input logic [XLEN-1:0] v);
        case (op)
            OP_SLL:  return v << 1;
            OP_SRL:  return v >> 1;
            default: return {v[XLEN-1], v[XLEN-1:1]};
        endcase
    endfunction

    logic [4:0]      shamt;
    logic            legal;
    logic            goes_busy;
    logic [XLEN-1:0] quick_res;
    logic [XLEN-1:0] acc_step;

    always_comb begin
        shamt     = bus.op_b[4:0];
        legal     = is_legal(bus.alu_op);
        goes_busy = legal && ((is_shift(bus.alu_op) && shamt != 5'd0) ||
                              bus.alu_op == OP_MUL);
        // Only reached for non-busy ops: a shift here has shamt=0 and passes op_a.
        if (!legal)
            quick_res = '0;
        else if (is_shift(bus.alu_op))
            quick_res = bus.op_a;
        else
            quick_res = simple_op(bus.alu_op, bus.op_a, bus.op_b);

        if (op_q == OP_MUL)
            acc_step = acc + (mplier[0] ? mcand : '0);
        else
            acc_step = shift_one(op_q, acc);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = goes_busy ? BUSY : DONE;
            BUSY:    if (count == 6'd1) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.result    = result_q;
        bus.zero      = zero_q;
        bus.illegal   = illegal_q;
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q <= bus.alu_op;
                        if (goes_busy) begin
                            if (bus.alu_op == OP_MUL) begin
                                acc    <= '0;
                                mcand  <= bus.op_a;
                                mplier <= bus.op_b;
                                count  <= 6'd32;
                            end else begin
                                acc    <= bus.op_a;
                                count  <= {1'b0, shamt};
                            end
                        end else begin
                            result_q  <= quick_res;
                            zero_q    <= (quick_res == '0);
                            illegal_q <= !legal;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_step;
                    count <= count - 6'd1;
                    if (op_q == OP_MUL) begin
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (count == 6'd1) begin
                        result_q  <= acc_step;
                        zero_q    <= (acc_step == '0);
                        illegal_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage unit directly downstream of alu_control. It consumes the 4-bit alu_op code together with two 32-bit operands and produces a registered result plus a zero flag.
- Simple ops complete in one cycle. Shifts run one bit per cycle and MUL runs as a 32-step shift-add, both behind a valid/ready handshake.
- Intended for the multi-cycle datapath variant: the control FSM stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width (only 32 is supported)
- MUL_EN, 1, when 0 the MUL code is treated as illegal

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  unit can accept (high only in IDLE)
- alu_op  input  4  operation code from alu_control
- op_a  input  XLEN  operand A (rs1)
- op_b  input  XLEN  operand B (rs2 or immediate); shift amount is op_b[4:0]
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- result  output  XLEN  registered result
- zero  output  1  result == 0 (for branch decision)
- illegal  output  1  alu_op was not a supported code

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed; result 1 or 0), 0011 XOR.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1100 MUL: low 32 bits, unsigned shift-add; the low 32 bits are sign-agnostic.
  - Any other code is illegal.
- Reset (rst_n low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; result=0; zero=1; illegal=0.
  - All internal counters and accumulators are cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch alu_op, op_a, op_b. Then:
    - Single-cycle op or illegal code: compute, register result, go to DONE.
    - Shift with shamt=0: result=op_a, go to DONE.
    - Shift with shamt>0: go to BUSY, count=shamt, acc=op_a.
    - MUL: go to BUSY, count=32, acc=0, multiplicand=op_a, multiplier=op_b.
- BUSY:
  - in_ready=0.
  - Each cycle, apply one step and decrement count:
    - Shift: acc shifted by 1 bit (SRA replicates bit 31).
    - MUL: if multiplier[0], acc+=multiplicand; then multiplicand<<=1 and multiplier>>=1.
  - When count reaches 0 after the step, load result=acc and go to DONE.
- DONE:
  - out_valid=1.
  - result, zero and illegal stay stable until out_ready=1. On that edge go to IDLE.
  - No new operation is accepted in the same cycle as output consumption.
- Latency, counted as accept edge to first cycle out_valid=1:
  - 1 cycle for single-cycle/illegal ops and shamt=0.
  - shamt+1 cycles for shifts.
  - 33 cycles for MUL.
- Arithmetic: all operations wrap modulo 2^32; no overflow flag. SLT compares as two's complement.
- Illegal code: result=0, zero=1, illegal=1, passed through the normal DONE handshake.
- zero and illegal are registered together with result.
- Inputs are ignored while in BUSY or DONE. Operand changes after acceptance have no effect.
- Reset asserted mid-BUSY or in DONE: immediate return to reset values; the in-flight operation is discarded with no out_valid.
- out_valid never deasserts without an out_ready handshake.
- in_valid held high continuously: a back-to-back op is accepted on the first IDLE cycle.

Test Plan:
- Reset release, then ADD op_a=5 op_b=7 -> out_valid one cycle after accept, result=0x0000000C, zero=0.
- SUB 3-3 -> result=0, zero=1. SLT 0xFFFFFFFF vs 1 -> result=1.
- SRA op_a=0x80000000 op_b=4 -> in_ready=0 for 4 BUSY cycles, result=0xF8000000 at latency 5. SLL with shamt=0 -> result=op_a at latency 1.
- MUL 0xFFFFFFFF*3 -> result=0xFFFFFFFD at latency 33. MUL 0x10000*0x10000 -> result=0, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after a DONE result.
  - out_valid and result are held for those 10 cycles.
  - in_ready=0 while out_ready is low.
  - Raising out_ready for one cycle returns the unit to IDLE.
- Illegal code 1111 -> illegal=1, result=0. Pulse rst_n low during MUL cycle 10 -> out_valid=0, in_ready=1, and no stale result after release.
